// File: rtl/baud_tick_gen.sv
// UART bit-timing generator: programmable divisor, mid-bit and bit-end ticks,
// oversample ticks realigned every bit, and optional frame-length counting.
module baud_tick_gen #(
  parameter int CLK_FRE    = 50,
  parameter int BAUD_RATE  = 9600,
  parameter int DIV_W      = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bps_start,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_val,
  input  logic [3:0]       frame_bits,
  output logic             clk_bps,
  output logic             bit_end,
  output logic             os_tick,
  output logic [3:0]       bit_idx,
  output logic             busy,
  output logic             frame_done,
  output logic [DIV_W-1:0] div_cur
);

  localparam int               OS_SHIFT    = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(CLK_FRE * 1_000_000 / BAUD_RATE);
  localparam logic [DIV_W-1:0] MIN_DIV     = DIV_W'(4);
  localparam logic [DIV_W-1:0] ONE         = DIV_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] cnt_reg, cnt_next;
  logic [DIV_W-1:0] os_cnt_reg, os_cnt_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [3:0]       bit_idx_reg, bit_idx_next;
  logic             clk_bps_reg, clk_bps_next;
  logic             bit_end_reg, bit_end_next;
  logic             os_tick_reg, os_tick_next;
  logic             frame_done_reg, frame_done_next;
  logic             busy_reg, busy_next;

  logic [DIV_W-1:0] div_last;
  logic [DIV_W-1:0] div_half;
  logic [DIV_W-1:0] os_raw;
  logic [DIV_W-1:0] os_div;
  logic [DIV_W-1:0] os_last;
  logic             bit_wrap;
  logic             os_wrap;
  logic             last_bit;

  // Oversample period is the bit period scaled down, never below one clock.
  assign div_last = div_reg - ONE;
  assign div_half = div_reg >> 1;
  assign os_raw   = div_reg >> OS_SHIFT;
  assign os_div   = (os_raw == '0) ? ONE : os_raw;
  assign os_last  = os_div - ONE;
  assign bit_wrap = (cnt_reg == div_last);
  assign os_wrap  = (os_cnt_reg == os_last);
  assign last_bit = (frame_bits != 4'd0) && (bit_idx_reg == frame_bits - 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      os_cnt_reg     <= '0;
      div_reg        <= DEFAULT_DIV;
      bit_idx_reg    <= 4'd0;
      clk_bps_reg    <= 1'b0;
      bit_end_reg    <= 1'b0;
      os_tick_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      os_cnt_reg     <= os_cnt_next;
      div_reg        <= div_next;
      bit_idx_reg    <= bit_idx_next;
      clk_bps_reg    <= clk_bps_next;
      bit_end_reg    <= bit_end_next;
      os_tick_reg    <= os_tick_next;
      frame_done_reg <= frame_done_next;
      busy_reg       <= busy_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    os_cnt_next     = os_cnt_reg;
    div_next        = div_reg;
    bit_idx_next    = bit_idx_reg;
    busy_next       = busy_reg;
    clk_bps_next    = 1'b0;
    bit_end_next    = 1'b0;
    os_tick_next    = 1'b0;
    frame_done_next = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next     = '0;
        os_cnt_next  = '0;
        bit_idx_next = 4'd0;
        busy_next    = 1'b0;
        if (div_load) begin
          div_next = (div_val < MIN_DIV) ? MIN_DIV : div_val;
        end
        if (bps_start) begin
          state_next = RUN;
          busy_next  = 1'b1;
        end
      end

      RUN: begin
        if (!bps_start) begin
          // Abort wins over any compare that matched on this edge.
          state_next   = IDLE;
          cnt_next     = '0;
          os_cnt_next  = '0;
          bit_idx_next = 4'd0;
          busy_next    = 1'b0;
        end else begin
          clk_bps_next = (cnt_reg == div_half);
          bit_end_next = bit_wrap;
          os_tick_next = os_wrap;
          cnt_next     = bit_wrap ? '0 : cnt_reg + ONE;
          os_cnt_next  = (bit_wrap || os_wrap) ? '0 : os_cnt_reg + ONE;
          if (bit_wrap) begin
            if (last_bit) begin
              frame_done_next = 1'b1;
              state_next      = DONE;
              busy_next       = 1'b0;
              bit_idx_next    = 4'd0;
            end else begin
              bit_idx_next = bit_idx_reg + 4'd1;
            end
          end
        end
      end

      DONE: begin
        // Wait for the start level to drop so a held level cannot retrigger.
        cnt_next     = '0;
        os_cnt_next  = '0;
        bit_idx_next = 4'd0;
        busy_next    = 1'b0;
        if (!bps_start) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next   = IDLE;
        cnt_next     = '0;
        os_cnt_next  = '0;
        bit_idx_next = 4'd0;
        busy_next    = 1'b0;
      end
    endcase
  end

  assign clk_bps    = clk_bps_reg;
  assign bit_end    = bit_end_reg;
  assign os_tick    = os_tick_reg;
  assign bit_idx    = bit_idx_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign div_cur    = div_reg;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: expected pulse timing comes from closed-form
// cycle arithmetic relative to the edge that enters RUN.
module tb_baud_tick_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bps_start = 1'b0;
  logic        div_load = 1'b0;
  logic [15:0] div_val = 16'd0;
  logic [3:0]  frame_bits = 4'd0;
  logic        clk_bps, bit_end, os_tick, busy, frame_done;
  logic [3:0]  bit_idx;
  logic [15:0] div_cur;

  int total = 0;
  int bad = 0;

  baud_tick_gen dut (
    .clk(clk), .rst(rst), .bps_start(bps_start), .div_load(div_load),
    .div_val(div_val), .frame_bits(frame_bits), .clk_bps(clk_bps),
    .bit_end(bit_end), .os_tick(os_tick), .bit_idx(bit_idx), .busy(busy),
    .frame_done(frame_done), .div_cur(div_cur)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] obs();
    return {clk_bps, bit_end, os_tick, frame_done, busy, bit_idx};
  endfunction

  // Expected {clk_bps,bit_end,os_tick,frame_done,busy,bit_idx} after edge k of RUN
  // (edge 0 is the one that enters RUN) for divisor div and frame length frame.
  function automatic logic [8:0] model(int k, int div, int frame);
    int pos, bitn, osd;
    logic act, bsy;
    logic [3:0] bi;
    pos  = (k - 1) % div;
    bitn = (k - 1) / div;
    osd  = div / 16;
    if (osd < 1) osd = 1;
    act  = (frame == 0) || (bitn < frame);
    bsy  = (frame == 0) || (k < div * frame);
    if (frame == 0) bi = 4'((k / div) % 16);
    else            bi = (k < div * frame) ? 4'(k / div) : 4'd0;
    return {act && (pos == div / 2), act && (pos == div - 1),
            act && ((pos % osd) == osd - 1), (frame != 0) && (k == div * frame), bsy, bi};
  endfunction

  task automatic test_reset();
    rst = 1'b1; bps_start = 1'b0; div_load = 1'b0; frame_bits = 4'd0;
    repeat (3) tick();
    total++;
    if (obs() !== 9'd0) begin
      bad++; $display("FAIL reset_outputs: got %b want %b", obs(), 9'd0);
    end
    total++;
    if (div_cur !== 16'd5208) begin
      bad++; $display("FAIL reset_div: got %0d want 5208", div_cur);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_free_run();
    int nbad = 0, first_bad = -1, first_bps = -1, first_end = -1, n_os = 0;
    logic [8:0] e, o, e_bad = '0, o_bad = '0;
    frame_bits = 4'd0; bps_start = 1'b1;
    tick();
    for (int k = 1; k <= 10430; k++) begin
      tick();
      e = model(k, 5208, 0); o = obs();
      if (o !== e) begin
        if (nbad == 0) begin first_bad = k; e_bad = e; o_bad = o; end
        nbad++;
      end
      if (clk_bps && first_bps < 0) first_bps = k;
      if (bit_end && first_end < 0) first_end = k;
      if (os_tick) n_os++;
    end
    total++;
    if (nbad !== 0) begin
      bad++; $display("FAIL free_run_trace: %0d bad cycles, first at %0d got %b want %b", nbad, first_bad, o_bad, e_bad);
    end
    total++;
    if (first_bps !== 2605) begin
      bad++; $display("FAIL free_run_first_bps: got cycle %0d want 2605", first_bps);
    end
    total++;
    if (first_end !== 5208) begin
      bad++; $display("FAIL free_run_first_bit_end: got cycle %0d want 5208", first_end);
    end
    total++;
    if (n_os !== 32) begin
      bad++; $display("FAIL free_run_os_count: got %0d want 32", n_os);
    end
    bps_start = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL free_run_stop_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_frame();
    int nbad = 0, first_bad = -1, fd_at = -1, n_bps = 0, n_end = 0, last_bps = -1;
    logic [8:0] e, o, m, e_bad = '0, o_bad = '0;
    div_load = 1'b1; div_val = 16'd100; frame_bits = 4'd10;
    tick();
    div_load = 1'b0;
    total++;
    if (div_cur !== 16'd100) begin
      bad++; $display("FAIL frame_div_load: got %0d want 100", div_cur);
    end
    bps_start = 1'b1;
    tick();
    for (int k = 1; k <= 1100; k++) begin
      tick();
      m = (k == 1000) ? 9'b111101111 : 9'h1FF;
      e = model(k, 100, 10); o = obs();
      if ((o & m) !== (e & m)) begin
        if (nbad == 0) begin first_bad = k; e_bad = e; o_bad = o; end
        nbad++;
      end
      if (frame_done && fd_at < 0) fd_at = k;
      if (clk_bps) begin n_bps++; last_bps = k; end
      if (bit_end) n_end++;
    end
    total++;
    if (nbad !== 0) begin
      bad++; $display("FAIL frame_trace: %0d bad cycles, first at %0d got %b want %b", nbad, first_bad, o_bad, e_bad);
    end
    total++;
    if (fd_at !== 1000) begin
      bad++; $display("FAIL frame_done_cycle: got %0d want 1000", fd_at);
    end
    total++;
    if (n_bps !== 10 || last_bps !== 951) begin
      bad++; $display("FAIL frame_bps: got count %0d last %0d want count 10 last 951", n_bps, last_bps);
    end
    total++;
    if (n_end !== 10) begin
      bad++; $display("FAIL frame_bit_end_count: got %0d want 10", n_end);
    end
    bps_start = 1'b0;
    tick();
  endtask

  task automatic test_load_in_run();
    frame_bits = 4'd0; bps_start = 1'b1;
    tick();
    repeat (30) tick();
    div_load = 1'b1; div_val = 16'd20;
    tick();
    div_load = 1'b0;
    total++;
    if (div_cur !== 16'd100 || busy !== 1'b1) begin
      bad++; $display("FAIL load_in_run: got div %0d busy %b want div 100 busy 1", div_cur, busy);
    end
    bps_start = 1'b0;
    tick();
    div_load = 1'b1; div_val = 16'd20;
    tick();
    div_load = 1'b0;
    total++;
    if (div_cur !== 16'd20) begin
      bad++; $display("FAIL load_in_idle: got %0d want 20", div_cur);
    end
  endtask

  task automatic test_min_div();
    int nbad = 0, first_bad = -1, n_os = 0;
    logic [8:0] e, o;
    div_load = 1'b1; div_val = 16'd2;
    tick();
    div_load = 1'b0;
    total++;
    if (div_cur !== 16'd4) begin
      bad++; $display("FAIL min_div_clamp: got %0d want 4", div_cur);
    end
    bps_start = 1'b1;
    tick();
    for (int k = 1; k <= 24; k++) begin
      tick();
      e = model(k, 4, 0); o = obs();
      if (o !== e) begin
        if (nbad == 0) first_bad = k;
        nbad++;
      end
      if (os_tick) n_os++;
    end
    total++;
    if (nbad !== 0) begin
      bad++; $display("FAIL min_div_trace: %0d bad cycles, first at %0d", nbad, first_bad);
    end
    total++;
    if (n_os !== 24) begin
      bad++; $display("FAIL min_div_os_every_cycle: got %0d ticks want 24", n_os);
    end
    bps_start = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int nbad = 0;
    div_load = 1'b1; div_val = 16'd100; frame_bits = 4'd0;
    tick();
    div_load = 1'b0;
    bps_start = 1'b1;
    tick();
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (obs() !== model(k, 100, 0)) nbad++;
    end
    total++;
    if (nbad !== 0) begin
      bad++; $display("FAIL abort_pre_trace: %0d bad cycles want 0", nbad);
    end
    bps_start = 1'b0;
    tick();
    total++;
    if (clk_bps !== 1'b0 || busy !== 1'b0 || bit_idx !== 4'd0 || os_tick !== 1'b0) begin
      bad++; $display("FAIL abort_edge: got bps %b busy %b idx %0d os %b want 0 0 0 0", clk_bps, busy, bit_idx, os_tick);
    end
    tick();
    total++;
    if (clk_bps !== 1'b0 || bit_end !== 1'b0) begin
      bad++; $display("FAIL abort_after: got bps %b end %b want 0 0", clk_bps, bit_end);
    end
  endtask

  task automatic test_reset_mid_frame();
    int nbad = 0, first_bad = -1, first_bps = -1, first_end = -1;
    frame_bits = 4'd10; bps_start = 1'b1;
    tick();
    for (int k = 1; k <= 520; k++) begin
      tick();
      if (obs() !== model(k, 100, 10)) nbad++;
    end
    total++;
    if (nbad !== 0 || bit_idx !== 4'd5) begin
      bad++; $display("FAIL mid_frame_pre: %0d bad cycles idx %0d want 0 bad idx 5", nbad, bit_idx);
    end
    rst = 1'b1;
    tick();
    total++;
    if (obs() !== 9'd0 || div_cur !== 16'd5208) begin
      bad++; $display("FAIL mid_frame_reset: got %b div %0d want 0 div 5208", obs(), div_cur);
    end
    rst = 1'b0; frame_bits = 4'd0; nbad = 0;
    tick();
    for (int k = 1; k <= 5300; k++) begin
      tick();
      if (obs() !== model(k, 5208, 0)) begin
        if (nbad == 0) first_bad = k;
        nbad++;
      end
      if (clk_bps && first_bps < 0) first_bps = k;
      if (bit_end && first_end < 0) first_end = k;
    end
    total++;
    if (nbad !== 0) begin
      bad++; $display("FAIL restart_trace: %0d bad cycles, first at %0d", nbad, first_bad);
    end
    total++;
    if (first_bps !== 2605 || first_end !== 5208) begin
      bad++; $display("FAIL restart_timing: got bps %0d end %0d want 2605 5208", first_bps, first_end);
    end
    bps_start = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_frame();
    test_load_in_run();
    test_min_div();
    test_abort();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
